// File: rtl/balance_pkg.sv
// Shared types, constants and saturation helpers for the balance-control PID sequencer.
package balance_pkg;

  localparam int unsigned PID_W   = 12;
  localparam int unsigned INTEG_W = 18;
  localparam int unsigned PTCH_W  = 16;
  localparam int unsigned PSAT_W  = 10;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned OPA_W   = 16;
  localparam int unsigned OPB_W   = 9;
  localparam int unsigned PROD_W  = OPA_W + OPB_W;

  localparam logic [4:0] P_COEFF_DEF = 5'h09;
  localparam logic [3:0] D_COEFF_DEF = 4'h1;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PMUL  = 3'd1;
  localparam logic [2:0] ST_DMUL  = 3'd2;
  localparam logic [2:0] ST_SCALE = 3'd3;
  localparam logic [2:0] ST_SAT   = 3'd4;

  // MAC operations
  localparam logic [1:0] MAC_HOLD   = 2'd0;
  localparam logic [1:0] MAC_LOAD   = 2'd1;  // acc = a*b
  localparam logic [1:0] MAC_ACCSUB = 2'd2;  // acc = acc + addend - a*b
  localparam logic [1:0] MAC_SCALE  = 2'd3;  // acc = (a*b) >>> 8

  // Clamp a 16-bit signed value to [-512, 511]
  function automatic logic signed [PSAT_W-1:0] sat10(input logic signed [PTCH_W-1:0] x);
    if (x > 16'sd511)       return 10'sd511;
    else if (x < -16'sd512) return -10'sd512;
    else                    return PSAT_W'(x);
  endfunction

  // Clamp a 16-bit signed value to [-2048, 2047]
  function automatic logic signed [PID_W-1:0] sat12(input logic signed [ACC_W-1:0] x);
    if (x > 16'sd2047)       return 12'sd2047;
    else if (x < -16'sd2048) return -12'sd2048;
    else                     return PID_W'(x);
  endfunction

endpackage

// File: rtl/pid_mac.sv
// Shared 16x9 signed multiply-accumulate with a 16-bit accumulator.
module pid_mac
  import balance_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              op,
  input  logic signed [OPA_W-1:0] opa,
  input  logic signed [OPB_W-1:0] opb,
  input  logic signed [ACC_W-1:0] addend,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc_nxt_c;

  assign prod_c = PROD_W'(opa) * PROD_W'(opb);

  // Accumulator next value per operation
  always_comb begin
    acc_nxt_c = acc;
    case (op)
      MAC_LOAD:   acc_nxt_c = ACC_W'(prod_c);
      MAC_ACCSUB: acc_nxt_c = acc + addend - ACC_W'(prod_c);
      MAC_SCALE:  acc_nxt_c = ACC_W'(prod_c >>> 8);
      default:    acc_nxt_c = acc;
    endcase
  end

  // Accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc_nxt_c;
  end

endmodule

// File: rtl/balance_seq.sv
// Balance-control PID sequencer: sample capture, P/I/D sequencing on a shared MAC,
// 12-bit saturation, integrator with overflow hold, soft-start timer.
// Optional SOFT_START_SCALE_EN adds a SCALE state that multiplies the sum by ss_tmr/256.
module balance_seq
  import balance_pkg::*;
#(
  parameter logic [4:0]  P_COEFF  = P_COEFF_DEF,
  parameter logic [3:0]  D_COEFF  = D_COEFF_DEF,
  parameter int unsigned SS_WIDTH = 27
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vld,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic signed [PTCH_W-1:0] ptch_rt,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun,
  output logic [7:0]              ss_tmr,
  output logic signed [PID_W-1:0] PID_cntrl
);

  logic [2:0]                state_q, state_nxt_c;
  logic signed [PSAT_W-1:0]  cap_ptch_c, work_ptch_q, hold_ptch_q;
  logic signed [PTCH_W-1:0]  work_rt_q, hold_rt_q;
  logic                      pend_q;
  logic signed [INTEG_W-1:0] integ_q, integ_ext_c, integ_sum_c;
  logic                      integ_ovf_c;
  logic [SS_WIDTH-1:0]       ss_cnt_q;
  logic [1:0]                mac_op_c;
  logic signed [OPA_W-1:0]   mac_opa_c;
  logic signed [OPB_W-1:0]   mac_opb_c;
  logic signed [ACC_W-1:0]   mac_add_c, mac_acc;

  assign cap_ptch_c  = sat10(ptch);
  assign integ_ext_c = INTEG_W'(work_ptch_q);
  assign integ_sum_c = integ_q + integ_ext_c;
  assign integ_ovf_c = (integ_q[INTEG_W-1] == integ_ext_c[INTEG_W-1]) &&
                       (integ_sum_c[INTEG_W-1] != integ_q[INTEG_W-1]);
  assign ss_tmr      = ss_cnt_q[SS_WIDTH-1 -: 8];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt_c;
      busy    <= (state_nxt_c != ST_IDLE);
    end
  end

  // Next state and MAC control
  always_comb begin
    state_nxt_c = state_q;
    mac_op_c    = MAC_HOLD;
    mac_opa_c   = '0;
    mac_opb_c   = '0;
    mac_add_c   = '0;
    case (state_q)
      ST_IDLE: if (vld || pend_q) state_nxt_c = ST_PMUL;
      ST_PMUL: begin
        state_nxt_c = ST_DMUL;
        mac_op_c    = MAC_LOAD;
        mac_opa_c   = OPA_W'(work_ptch_q);
        mac_opb_c   = {4'b0, P_COEFF};
      end
      ST_DMUL: begin
`ifdef SOFT_START_SCALE_EN
        state_nxt_c = ST_SCALE;
`else
        state_nxt_c = ST_SAT;
`endif
        mac_op_c    = MAC_ACCSUB;
        mac_opa_c   = work_rt_q >>> 6;
        mac_opb_c   = {5'b0, D_COEFF};
        mac_add_c   = ACC_W'(integ_q >>> 6);
      end
`ifdef SOFT_START_SCALE_EN
      ST_SCALE: begin
        state_nxt_c = ST_SAT;
        mac_op_c    = MAC_SCALE;
        mac_opa_c   = mac_acc;
        mac_opb_c   = {1'b0, ss_tmr};
      end
`endif
      ST_SAT:  state_nxt_c = ST_IDLE;
      default: state_nxt_c = ST_IDLE;
    endcase
  end

  // Sample capture, holding register and overrun detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_ptch_q <= '0;
      work_rt_q   <= '0;
      hold_ptch_q <= '0;
      hold_rt_q   <= '0;
      pend_q      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (pend_q) begin
          work_ptch_q <= hold_ptch_q;
          work_rt_q   <= hold_rt_q;
          if (vld) begin
            hold_ptch_q <= cap_ptch_c;
            hold_rt_q   <= ptch_rt;
          end else begin
            pend_q <= 1'b0;
          end
        end else if (vld) begin
          work_ptch_q <= cap_ptch_c;
          work_rt_q   <= ptch_rt;
        end
      end else if (vld) begin
        hold_ptch_q <= cap_ptch_c;
        hold_rt_q   <= ptch_rt;
        pend_q      <= 1'b1;
        overrun     <= pend_q;
      end
    end
  end

  // Integrator: clear on rider_off, else add in PMUL unless the add overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      integ_q <= '0;
    else if (rider_off)                           integ_q <= '0;
    else if (state_q == ST_PMUL && !integ_ovf_c)  integ_q <= integ_sum_c;
  end

  // Saturated output and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PID_cntrl <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == ST_SAT) begin
        PID_cntrl <= sat12(mac_acc);
        done      <= 1'b1;
      end
    end
  end

  // Soft-start counter, saturating at top byte 8'hFF
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ss_cnt_q <= '0;
    else if (!pwr_up)                     ss_cnt_q <= '0;
    else if (ss_tmr != 8'hFF)             ss_cnt_q <= ss_cnt_q + SS_WIDTH'(1);
  end

  pid_mac u_mac (
    .clk    (clk),
    .rst    (rst),
    .op     (mac_op_c),
    .opa    (mac_opa_c),
    .opb    (mac_opb_c),
    .addend (mac_add_c),
    .acc    (mac_acc)
  );

endmodule

// File: tb/tb_balance_seq.sv
// Directed self-checking bench for balance_seq (default build, latency 3).
module tb_balance_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        pwr_up;
  logic        rider_off;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [7:0]  ss_tmr;
  logic [11:0] PID_cntrl;

  int vectors     = 0;
  int miscompares = 0;

  balance_seq #(.SS_WIDTH(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .pwr_up    (pwr_up),
    .rider_off (rider_off),
    .ptch      (ptch),
    .ptch_rt   (ptch_rt),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun),
    .ss_tmr    (ss_tmr),
    .PID_cntrl (PID_cntrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One sample from IDLE; done expected exactly 3 edges after vld is sampled
  task automatic run_sample(input string tag, input logic [15:0] p, input logic [15:0] r,
                            input logic [11:0] exp);
    logic early;
    early   = 1'b0;
    ptch    = p;
    ptch_rt = r;
    vld     = 1'b1;
    tick();
    vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (done) early = 1'b1;
    end
    tick();
    chk({tag, "_done"}, {31'b0, done & ~early}, 32'd1);
    chk({tag, "_pid"}, {20'b0, PID_cntrl}, {20'b0, exp});
    tick();
  endtask

  initial begin : stim
    int          n_done;
    int          n_ovr;
    int          second_idx;
    logic [11:0] pid_seen [2];

    rst = 1'b1; vld = 1'b0; pwr_up = 1'b0; rider_off = 1'b0;
    ptch = '0; ptch_rt = '0;
    tick(); tick();
    chk("rst_busy",    {31'b0, busy},    32'd0);
    chk("rst_done",    {31'b0, done},    32'd0);
    chk("rst_overrun", {31'b0, overrun}, 32'd0);
    chk("rst_ss_tmr",  {24'b0, ss_tmr},  32'd0);
    chk("rst_pid",     {20'b0, PID_cntrl}, 32'd0);
    rst = 1'b0;
    tick();

    // 9*256 + (256>>>6) = 2308 -> clamps to 2047
    run_sample("t1", 16'h0100, 16'h0000, 12'h7FF);

    // Reset mid-sequence with a pending sample: nothing completes
    ptch = 16'h0010; ptch_rt = 16'h0000; vld = 1'b1;
    tick();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    ptch = 16'h0020;
    tick();
    vld = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_pid",  {20'b0, PID_cntrl}, 32'd0);
    tick();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("mid_no_done", n_done, 32'd0);

    // P=144, I=16>>>6=0, D=-(1024>>>6)=-16 -> 128
    do_reset();
    run_sample("t2", 16'h0010, 16'h0400, 12'h080);

    // vld at N, N+1, N+2: overrun on the third, two dones, second uses third sample
    do_reset();
    ptch = 16'h0010; ptch_rt = 16'h0400; vld = 1'b1;
    tick();
    ptch = 16'h0100; ptch_rt = 16'h0000;
    tick();
    chk("ovr_not_yet", {31'b0, overrun}, 32'd0);
    ptch = 16'h0020; ptch_rt = 16'h0000;
    tick();
    vld = 1'b0;
    chk("ovr_pulse", {31'b0, overrun}, 32'd1);
    n_done = 0; n_ovr = 0; second_idx = -1;
    pid_seen[0] = '0; pid_seen[1] = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (overrun) n_ovr++;
      if (done) begin
        if (n_done < 2) pid_seen[n_done] = PID_cntrl;
        if (n_done == 1) second_idx = i;
        n_done++;
      end
    end
    chk("ovr_done_cnt", n_done, 32'd2);
    chk("ovr_single",   n_ovr,  32'd0);
    chk("ovr_pid1", {20'b0, pid_seen[0]}, 32'h080);
    // integ 16+32=48 -> I=0; P=288
    chk("ovr_pid2", {20'b0, pid_seen[1]}, 32'h120);
    chk("ovr_lat2", second_idx, 32'd4);

    // vld in the SAT cycle becomes pending, no overrun
    do_reset();
    ptch = 16'h0010; ptch_rt = 16'h0400; vld = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    tick();
    ptch = 16'hFF00; ptch_rt = 16'h0000; vld = 1'b1;
    tick();
    vld = 1'b0;
    chk("satv_done1",  {31'b0, done}, 32'd1);
    chk("satv_pid1",   {20'b0, PID_cntrl}, 32'h080);
    n_done = 0; n_ovr = 0;
    if (overrun) n_ovr++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (overrun) n_ovr++;
      if (done) n_done++;
    end
    chk("satv_done2", n_done, 32'd1);
    chk("satv_no_ovr", n_ovr, 32'd0);
    // P=-2304, I=(16-256)>>>6=-4 -> -2308 clamps to -2048
    chk("satv_pid2", {20'b0, PID_cntrl}, 32'h800);

    // P=-144, I=-16>>>6=-1, D=+16 -> -129
    do_reset();
    run_sample("neg", 16'hFFF0, 16'hFC00, 12'hF7F);

    // sat10 on input: 0x7FFF enters the integrator as 511 -> I=7
    do_reset();
    run_sample("s10a", 16'h7FFF, 16'h0000, 12'h7FF);
    run_sample("s10b", 16'h0000, 16'h0000, 12'h007);

    // Integrator negative limit: 256 * -512 = -131072, then hold
    do_reset();
    for (int i = 0; i < 255; i++) run_sample("neg_sat", 16'h8000, 16'h0000, 12'h800);
    run_sample("i255", 16'h0000, 16'h0000, 12'h808);
    run_sample("i256a", 16'h8000, 16'h0000, 12'h800);
    run_sample("i256", 16'h0000, 16'h0000, 12'h800);
    for (int i = 0; i < 3; i++) run_sample("ihold_s", 16'h8000, 16'h0000, 12'h800);
    run_sample("ihold", 16'h0000, 16'h0000, 12'h800);

    // rider_off during PMUL clears an integrator of 4096 and the sequence finishes
    do_reset();
    for (int i = 0; i < 16; i++) run_sample("ro_fill", 16'h0100, 16'h0000, 12'h7FF);
    run_sample("ro_pre", 16'h0000, 16'h0000, 12'h040);
    ptch = 16'h0000; ptch_rt = 16'h0000; vld = 1'b1;
    tick();
    vld = 1'b0; rider_off = 1'b1;
    tick();
    rider_off = 1'b0;
    tick();
    tick();
    chk("ro_done", {31'b0, done}, 32'd1);
    chk("ro_pid",  {20'b0, PID_cntrl}, 32'd0);
    tick();
    run_sample("ro_post", 16'h0000, 16'h0000, 12'h000);

    // Soft-start counter (10-bit build): ss_tmr = count >> 2, saturates at 0x3FC
    pwr_up = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("ss_8", {24'b0, ss_tmr}, 32'h02);
    repeat (1011) @(posedge clk);
    #1;
    chk("ss_1019", {24'b0, ss_tmr}, 32'hFE);
    tick();
    chk("ss_1020", {24'b0, ss_tmr}, 32'hFF);
    repeat (200) @(posedge clk);
    #1;
    chk("ss_hold", {24'b0, ss_tmr}, 32'hFF);
    pwr_up = 1'b0;
    tick();
    chk("ss_clear", {24'b0, ss_tmr}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
